bip_control_unit: RTL and testbench

- Sequencer and decoder for the accumulator CPU.
- Sits directly upstream of the datapath and drives its SelA/SelB/WrAcc/Op/Operand controls.
- Fetches 16-bit instructions from program memory, splits each into a 5-bit opcode and an 11-bit operand, and issues one execute cycle per instruction.
- Runs until an HLT instruction, after which it stays halted.

---
 rtl/bip_control_unit_if.sv | 39 +++
 rtl/bip_control_unit.sv | 121 ++++++++++++
 tb/tb_bip_control_unit.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/bip_control_unit_if.sv
// Control-unit bus: program memory fetch, start/halt and the datapath controls.
// Macro BIP_CYCLE_COUNT_EN adds the o_cycles counter output.
interface bip_control_unit_if #(
    parameter int NBITS_PC = 11,
    parameter int NBITS_O  = 11,
    parameter int NBITS_I  = 16
`ifdef BIP_CYCLE_COUNT_EN
    , parameter int NBITS_CNT = 16
`endif
);
    logic                i_start;
    logic [NBITS_I-1:0]  i_Instruction;
    logic [NBITS_PC-1:0] o_AddrPM;
    logic [1:0]          o_SelA;
    logic                o_SelB;
    logic                o_WrAcc;
    logic                o_Op;
    logic                o_WrRam;
    logic                o_RdRam;
    logic [NBITS_O-1:0]  o_Operand;
    logic                o_halt;
`ifdef BIP_CYCLE_COUNT_EN
    logic [NBITS_CNT-1:0] o_cycles;

    modport master (output i_start, i_Instruction,
                    input  o_AddrPM, o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam,
                           o_Operand, o_halt, o_cycles);
    modport slave  (input  i_start, i_Instruction,
                    output o_AddrPM, o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam,
                           o_Operand, o_halt, o_cycles);
`else
    modport master (output i_start, i_Instruction,
                    input  o_AddrPM, o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam,
                           o_Operand, o_halt);
    modport slave  (input  i_start, i_Instruction,
                    output o_AddrPM, o_SelA, o_SelB, o_WrAcc, o_Op, o_WrRam, o_RdRam,
                           o_Operand, o_halt);
`endif
endinterface

// File: rtl/bip_control_unit.sv
// Fetch/execute sequencer and decoder for the BIP accumulator CPU.
// Macro BIP_CYCLE_COUNT_EN adds a saturating busy-cycle counter (o_cycles).
//
// state   | meaning
// --------+---------------------------------------------------
// S_IDLE  | waiting for i_start
// S_FETCH | latch instruction into IR, advance PC
// S_EXEC  | decode IR, drive datapath controls for one cycle
// S_HALT  | HLT executed; left only by reset
module bip_control_unit #(
    parameter int NBITS_PC = 11,
    parameter int NBITS_O  = 11,
    parameter int NBITS_OP = 5,
    parameter int NBITS_I  = 16
`ifdef BIP_CYCLE_COUNT_EN
    , parameter int NBITS_CNT = 16
`endif
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    bip_control_unit_if.slave     bus
);
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT} state_t;

    localparam logic [NBITS_OP-1:0] OP_HLT  = NBITS_OP'(0);
    localparam logic [NBITS_OP-1:0] OP_STO  = NBITS_OP'(1);
    localparam logic [NBITS_OP-1:0] OP_LD   = NBITS_OP'(2);
    localparam logic [NBITS_OP-1:0] OP_LDI  = NBITS_OP'(3);
    localparam logic [NBITS_OP-1:0] OP_ADD  = NBITS_OP'(4);
    localparam logic [NBITS_OP-1:0] OP_ADDI = NBITS_OP'(5);
    localparam logic [NBITS_OP-1:0] OP_SUB  = NBITS_OP'(6);
    localparam logic [NBITS_OP-1:0] OP_SUBI = NBITS_OP'(7);

    state_t              r_state;
    state_t              w_next;
    logic [NBITS_PC-1:0] r_pc;
    logic [NBITS_I-1:0]  r_ir;
    logic                r_halt;
    logic [NBITS_OP-1:0] w_opcode;
    logic [1:0]          w_sel_a;
    logic                w_sel_b;
    logic                w_wr_acc;
    logic                w_op;
    logic                w_wr_ram;
    logic                w_rd_ram;

    assign w_opcode = r_ir[NBITS_I-1 -: NBITS_OP];

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= S_IDLE;
            r_pc    <= '0;
            r_ir    <= '0;
            r_halt  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_halt  <= (w_next == S_HALT);
            if (r_state == S_FETCH) begin
                r_ir <= bus.i_Instruction;
                r_pc <= r_pc + NBITS_PC'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.i_start) w_next = S_FETCH;
            S_FETCH: w_next = S_EXEC;
            S_EXEC:  w_next = (w_opcode == OP_HLT) ? S_HALT : S_FETCH;
            S_HALT:  w_next = S_HALT;
            default: w_next = S_IDLE;
        endcase
    end

    // Controls exist only in EXEC; reset forcing IDLE clears them asynchronously.
    always_comb begin
        w_sel_a  = 2'b00;
        w_sel_b  = 1'b0;
        w_wr_acc = 1'b0;
        w_op     = 1'b0;
        w_wr_ram = 1'b0;
        w_rd_ram = 1'b0;
        if (r_state == S_EXEC) begin
            case (w_opcode)
                OP_STO:  w_wr_ram = 1'b1;
                OP_LD:   begin w_rd_ram = 1'b1; w_wr_acc = 1'b1; end
                OP_LDI:  begin w_sel_a = 2'b01; w_wr_acc = 1'b1; end
                OP_ADD:  begin w_rd_ram = 1'b1; w_sel_a = 2'b10; w_wr_acc = 1'b1; end
                OP_ADDI: begin w_sel_b = 1'b1; w_sel_a = 2'b10; w_wr_acc = 1'b1; end
                OP_SUB:  begin w_rd_ram = 1'b1; w_op = 1'b1; w_sel_a = 2'b10; w_wr_acc = 1'b1; end
                OP_SUBI: begin w_sel_b = 1'b1; w_op = 1'b1; w_sel_a = 2'b10; w_wr_acc = 1'b1; end
                default: ;
            endcase
        end
    end

    assign bus.o_AddrPM  = r_pc;
    assign bus.o_SelA    = w_sel_a;
    assign bus.o_SelB    = w_sel_b;
    assign bus.o_WrAcc   = w_wr_acc;
    assign bus.o_Op      = w_op;
    assign bus.o_WrRam   = w_wr_ram;
    assign bus.o_RdRam   = w_rd_ram;
    assign bus.o_Operand = r_ir[NBITS_O-1:0];
    assign bus.o_halt    = r_halt;

`ifdef BIP_CYCLE_COUNT_EN
    logic [NBITS_CNT-1:0] r_cycles;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_cycles <= '0;
        end else if ((r_state == S_FETCH || r_state == S_EXEC) && r_cycles != '1) begin
            r_cycles <= r_cycles + NBITS_CNT'(1);
        end
    end

    assign bus.o_cycles = r_cycles;
`endif
endmodule

// File: tb/tb_bip_control_unit.sv
// Bench for bip_control_unit: instruction-level reference model checked every cycle
// plus directed literal checks on the documented program scenarios.
module tb_bip_control_unit;
    localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HALT = 3;

    logic        i_clock = 1'b0;
    logic        i_reset = 1'b1;
    logic [15:0] mem [0:2047];
    int          n_checks = 0;
    int          n_errors = 0;

    bip_control_unit_if bus ();

    bip_control_unit dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    assign bus.i_Instruction = mem[bus.o_AddrPM];

    always #5 i_clock = ~i_clock;

    // Reference model: instruction-level view of the machine.
    int          m_mode   = M_IDLE;
    int          m_pc     = 0;
    logic [15:0] m_ir     = 16'h0000;
    int          m_cycles = 0;

    always @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            m_mode = M_IDLE; m_pc = 0; m_ir = 16'h0000; m_cycles = 0;
        end else begin
            if ((m_mode == M_FETCH || m_mode == M_EXEC) && m_cycles < 65535)
                m_cycles = m_cycles + 1;
            case (m_mode)
                M_IDLE:  if (bus.i_start) m_mode = M_FETCH;
                M_FETCH: begin m_ir = mem[m_pc]; m_pc = (m_pc + 1) % 2048; m_mode = M_EXEC; end
                M_EXEC:  m_mode = (m_ir[15:11] == 5'd0) ? M_HALT : M_FETCH;
                default: ;
            endcase
        end
    end

    // {SelA[1:0], SelB, WrAcc, Op, WrRam, RdRam}
    function automatic logic [6:0] dec(input logic [4:0] opc);
        case (opc)
            5'd1:    return 7'b00_0_0_0_1_0;
            5'd2:    return 7'b00_0_1_0_0_1;
            5'd3:    return 7'b01_0_1_0_0_0;
            5'd4:    return 7'b10_0_1_0_0_1;
            5'd5:    return 7'b10_1_1_0_0_0;
            5'd6:    return 7'b10_0_1_1_0_1;
            5'd7:    return 7'b10_1_1_1_0_0;
            default: return 7'b0;
        endcase
    endfunction

    logic [29:0] w_act, w_exp;
    assign w_act = {bus.o_AddrPM, bus.o_SelA, bus.o_SelB, bus.o_WrAcc, bus.o_Op,
                    bus.o_WrRam, bus.o_RdRam, bus.o_Operand, bus.o_halt};
    always_comb
        w_exp = {11'(m_pc), (m_mode == M_EXEC) ? dec(m_ir[15:11]) : 7'b0,
                 m_ir[10:0], (m_mode == M_HALT)};

    always @(negedge i_clock) begin
        if (i_reset === 1'b1) begin
            n_checks++;
            if (w_act !== w_exp) begin
                n_errors++;
                $display("FAIL cycle_outputs t=%0t got=%h expected=%h", $time, w_act, w_exp);
            end
`ifdef BIP_CYCLE_COUNT_EN
            n_checks++;
            if (bus.o_cycles !== 16'(m_cycles)) begin
                n_errors++;
                $display("FAIL cycle_count t=%0t got=%0d expected=%0d", $time, bus.o_cycles, m_cycles);
            end
`endif
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int ctl();
        return {bus.o_SelA, bus.o_SelB, bus.o_WrAcc, bus.o_Op, bus.o_WrRam, bus.o_RdRam};
    endfunction

    task automatic do_reset(input logic [15:0] fill);
        i_reset = 1'b0;
        bus.i_start = 1'b0;
        for (int a = 0; a < 2048; a++) mem[a] = fill;
        #12;
        @(posedge i_clock); #2;
        i_reset = 1'b1;
    endtask

    // Returns 2 time units after the edge that samples i_start (state FETCH).
    task automatic start_pulse();
        @(posedge i_clock); #2;
        bus.i_start = 1'b1;
        @(posedge i_clock); #2;
        bus.i_start = 1'b0;
    endtask

    task automatic wait_halt(input int budget, input int pc_exp, input string name);
        int n = 0;
        while (bus.o_halt !== 1'b1 && n < budget) begin
            @(negedge i_clock);
            n++;
        end
        chk({name, "_halt"}, int'(bus.o_halt === 1'b1), 1);
        chk({name, "_pc"}, int'(bus.o_AddrPM), pc_exp);
    endtask

    initial begin
        bus.i_start = 1'b0;
        #1;
        do_reset(16'h0000);

        // Idle with no start
        repeat (10) @(negedge i_clock);
        chk("idle_pc", int'(bus.o_AddrPM), 0);
        chk("idle_ctl", ctl(), 0);
        chk("idle_halt", int'(bus.o_halt), 0);

        // LDI 5; ADDI 3; STO 7; HLT
        do_reset(16'h0000);
        mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0807; mem[3] = 16'h0000;
        start_pulse();
        @(negedge i_clock);
        @(negedge i_clock);
        chk("ldi_ctl", ctl(), 7'b01_0_1_0_0_0);
        chk("ldi_operand", int'(bus.o_Operand), 5);
        repeat (2) @(negedge i_clock);
        chk("addi_ctl", ctl(), 7'b10_1_1_0_0_0);
        chk("addi_operand", int'(bus.o_Operand), 3);
        repeat (2) @(negedge i_clock);
        chk("sto_ctl", ctl(), 7'b00_0_0_0_1_0);
        chk("sto_operand", int'(bus.o_Operand), 7);
        repeat (2) @(negedge i_clock);
        chk("hlt_exec_halt_low", int'(bus.o_halt), 0);
        @(negedge i_clock);
        chk("prog1_halt", int'(bus.o_halt), 1);
        chk("prog1_pc", int'(bus.o_AddrPM), 4);
`ifdef BIP_CYCLE_COUNT_EN
        chk("prog1_cycles", int'(bus.o_cycles), 8);
`endif
        bus.i_start = 1'b1;
        repeat (20) @(negedge i_clock);
        bus.i_start = 1'b0;
        chk("halt_sticky", int'(bus.o_halt), 1);
        chk("halt_pc_frozen", int'(bus.o_AddrPM), 4);
        chk("halt_ctl", ctl(), 0);
`ifdef BIP_CYCLE_COUNT_EN
        chk("cycles_frozen", int'(bus.o_cycles), 8);
`endif

        // SUB 2; LD 2; HLT
        do_reset(16'h0000);
        mem[0] = 16'h3002; mem[1] = 16'h1002; mem[2] = 16'h0000;
        start_pulse();
        repeat (2) @(negedge i_clock);
        chk("sub_ctl", ctl(), 7'b10_0_1_1_0_1);
        chk("sub_operand", int'(bus.o_Operand), 2);
        repeat (2) @(negedge i_clock);
        chk("ld_ctl", ctl(), 7'b00_0_1_0_0_1);
        wait_halt(20, 3, "prog2");

        // Illegal opcode then HLT
        do_reset(16'h0000);
        mem[0] = 16'hF8FF; mem[1] = 16'h0000;
        start_pulse();
        repeat (2) @(negedge i_clock);
        chk("nop_ctl", ctl(), 0);
        chk("nop_operand", int'(bus.o_Operand), 255);
        chk("nop_not_halted", int'(bus.o_halt), 0);
        wait_halt(20, 2, "prog3");

        // PC wrap over a memory of NOPs, then reset during ADDI execute
        do_reset(16'h4000);
        mem[0] = 16'h2803;
        start_pulse();
        repeat (2) @(negedge i_clock);
        chk("wrap_first_pc", int'(bus.o_AddrPM), 1);
        chk("wrap_first_wracc", int'(bus.o_WrAcc), 1);
        repeat (4094) @(negedge i_clock);
        chk("wrap_pc_zero", int'(bus.o_AddrPM), 0);
        repeat (2) @(negedge i_clock);
        chk("wrap_addi_wracc", int'(bus.o_WrAcc), 1);
        chk("wrap_addi_pc", int'(bus.o_AddrPM), 1);
        i_reset = 1'b0;
        #1;
        chk("rst_wracc", int'(bus.o_WrAcc), 0);
        chk("rst_ctl", ctl(), 0);
        chk("rst_pc", int'(bus.o_AddrPM), 0);
        chk("rst_operand", int'(bus.o_Operand), 0);
        chk("rst_halt", int'(bus.o_halt), 0);
        @(posedge i_clock); #2;
        i_reset = 1'b1;
        repeat (5) @(negedge i_clock);
        chk("rst_idle_pc", int'(bus.o_AddrPM), 0);
        chk("rst_idle_ctl", ctl(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
